// File: rtl/riscv_vga_top.sv
// riscv_vga_top: single-cycle RV32I-subset core, instruction ROM,
// data RAM, memory-mapped colour register and 640x480 VGA timing.
module riscv_vga_top #(
  parameter     IMEM_FILE = "riscvtest.txt",
  parameter int MEM_WORDS = 64,
  parameter int PIX_DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS_O,
  output logic        VGA_VS_O
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam bit HAS_IMG = |IMEM_FILE;

  // Built-in image of the self-check program; a blank name gives an
  // all-NOP ROM.
  logic [31:0] imem [MEM_WORDS] = '{
    0: HAS_IMG ? 32'h00500093 : 32'h0,
    1: HAS_IMG ? 32'h00200113 : 32'h0,
    2: HAS_IMG ? 32'h002081B3 : 32'h0,
    3: HAS_IMG ? 32'h06102023 : 32'h0,
    4: HAS_IMG ? 32'h06302223 : 32'h0,
    5: HAS_IMG ? 32'h00000063 : 32'h0,
    default: 32'h0
  };

  logic [31:0] ram [MEM_WORDS];
  logic [31:0] rf  [32];

  logic [31:0] pc, pc_next, pc_plus4, instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd1, rd2, src_b, alu_y;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] rdata, wd;
  logic        is_lw, is_sw, is_r, is_i;
  logic        is_beq, is_jal;
  logic        alu_ok, reg_we, ram_sel, col_sel;
  logic [11:0] colour;
  logic [DW-1:0] div;
  logic [9:0]  h_cnt, v_cnt;
  logic        pix_tick, active;

  assign instr    = imem[pc[AW+1:2]];
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign f7b5     = instr[30];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  assign is_lw  = (opcode == 7'h03) && (funct3 == 3'b010);
  assign is_sw  = (opcode == 7'h23) && (funct3 == 3'b010);
  assign is_r   = (opcode == 7'h33);
  assign is_i   = (opcode == 7'h13);
  assign is_beq = (opcode == 7'h63) && (funct3 == 3'b000);
  assign is_jal = (opcode == 7'h6f);

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  always_comb begin
    src_b = imm_i;
    if (is_r)
      src_b = rd2;
    else if (is_sw)
      src_b = imm_s;
  end

  always_comb begin
    alu_y  = rd1 + src_b;
    alu_ok = 1'b0;
    if (is_r || is_i) begin
      case (funct3)
        3'b000: begin
          alu_y  = (is_r && f7b5) ? rd1 - src_b
                                  : rd1 + src_b;
          alu_ok = 1'b1;
        end
        3'b010: begin
          alu_y  = {31'd0,
                    $signed(rd1) < $signed(src_b)};
          alu_ok = 1'b1;
        end
        3'b110: begin
          alu_y  = rd1 | src_b;
          alu_ok = 1'b1;
        end
        3'b111: begin
          alu_y  = rd1 & src_b;
          alu_ok = 1'b1;
        end
        default: alu_ok = 1'b0;
      endcase
    end
  end

  assign DataAdr   = alu_y;
  assign WriteData = rd2;
  assign MemWrite  = is_sw;
  assign ram_sel   = DataAdr < 32'd256;
  assign col_sel   = DataAdr == 32'd256;
  assign rdata     = ram_sel ? ram[DataAdr[AW+1:2]] : 32'd0;

  always_comb begin
    reg_we = 1'b0;
    wd     = alu_y;
    unique case (1'b1)
      is_lw: begin
        reg_we = 1'b1;
        wd     = rdata;
      end
      is_jal: begin
        reg_we = 1'b1;
        wd     = pc_plus4;
      end
      is_r, is_i: reg_we = alu_ok;
      default:    reg_we = 1'b0;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      is_beq && (rd1 == rd2): pc_next = pc + imm_b;
      is_jal:                 pc_next = pc + imm_j;
      default:                pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      pc <= 32'd0;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset && reg_we && (rd != 5'd0))
      rf[rd] <= wd;
    if (!reset && is_sw && ram_sel)
      ram[DataAdr[AW+1:2]] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset)
      colour <= 12'd0;
    else if (is_sw && col_sel)
      colour <= WriteData[11:0];
  end

  assign pix_tick = (div == DW'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= '0;
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else begin
      div <= pix_tick ? '0 : div + 1'b1;
      if (pix_tick) begin
        if (h_cnt == 10'd799) begin
          h_cnt <= 10'd0;
          v_cnt <= (v_cnt == 10'd524) ? 10'd0
                                      : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign active = (h_cnt < 10'd640) && (v_cnt < 10'd480);

  assign VGA_R = active ? colour[11:8] : 4'd0;
  assign VGA_G = active ? colour[7:4]  : 4'd0;
  assign VGA_B = active ? colour[3:0]  : 4'd0;

  assign VGA_HS_O = reset |
    ~((h_cnt >= 10'd656) & (h_cnt <= 10'd751));
  assign VGA_VS_O = reset |
    ~((v_cnt >= 10'd490) & (v_cnt <= 10'd491));

endmodule

// File: tb/tb_riscv_vga_top.sv
// tb_riscv_vga_top: program-driven checks of the core, the colour
// register and VGA timing against a behavioural model.
module tb_riscv_vga_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] WriteData, DataAdr;
  logic        MemWrite;
  logic [3:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS_O, VGA_VS_O;

  riscv_vga_top dut (
    .clk(clk),
    .reset(reset),
    .WriteData(WriteData),
    .DataAdr(DataAdr),
    .MemWrite(MemWrite),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B),
    .VGA_HS_O(VGA_HS_O),
    .VGA_VS_O(VGA_VS_O)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [63:0] st_q[$];
  int          st_c[$];
  int          ncyc = 0;

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      ncyc = 0;
    end else begin
      if (MemWrite === 1'b1) begin
        st_q.push_back({DataAdr, WriteData});
        st_c.push_back(ncyc);
      end
      ncyc++;
    end
  end

  function automatic logic [31:0] enc_i(
    input int imm, input int f3, input int rd, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_lw(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'd0, 3'b010, 5'(rd), 7'h03};
  endfunction

  function automatic logic [31:0] enc_sw(input int imm, input int rs2);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'd0, 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(
    input int f7, input int f3, input int rd,
    input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(
    input int imm, input int rs1, input int rs2);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000,
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  task automatic start_prog(input logic [31:0] p[$]);
    reset = 1'b1;
    for (int i = 0; i < 64; i++)
      dut.imem[i] = (i < p.size()) ? p[i] : 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    st_q.delete();
    st_c.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({VGA_HS_O, VGA_VS_O} !== 2'b11) begin
      bad++;
      $display("FAIL rst_sync got %b want 11", {VGA_HS_O, VGA_VS_O});
    end
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("FAIL rst_pc got %h want 0", dut.pc);
    end
    reset = 1'b0;
    st_q.delete();
    st_c.delete();
    @(negedge clk);
    total++;
    if ({VGA_R, VGA_G, VGA_B, VGA_HS_O, MemWrite} !== 14'b10) begin
      bad++;
      $display("FAIL rst_out got %h want 2",
               {VGA_R, VGA_G, VGA_B, VGA_HS_O, MemWrite});
    end
  endtask

  task automatic test_default_prog(input string tag);
    logic [63:0] exp[$];
    int          ec[$];
    exp = '{{32'd96, 32'd5}, {32'd100, 32'd7}};
    ec  = '{3, 4};
    repeat (105) @(negedge clk);
    total++;
    if (st_q.size() !== exp.size()) begin
      bad++;
      $display("FAIL %s_nstores got %0d want %0d",
               tag, st_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < st_q.size(); i++) begin
      total++;
      if (st_q[i] !== exp[i] || st_c[i] !== ec[i]) begin
        bad++;
        $display("FAIL %s_store%0d got %h@%0d want %h@%0d",
                 tag, i, st_q[i], st_c[i], exp[i], ec[i]);
      end
    end
    total++;
    if (dut.pc !== 32'h14 || MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got pc=%h mw=%b want pc=14 mw=0",
               tag, dut.pc, MemWrite);
    end
  endtask

  task automatic test_mid_reset;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    st_q.delete();
    st_c.delete();
    @(negedge clk);
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("FAIL midrst_pc got %h want 0", dut.pc);
    end
    test_default_prog("replay");
  endtask

  task automatic test_alu_directed;
    logic [31:0] p[$];
    logic [63:0] exp[$];
    p = '{enc_i(-1, 0, 1, 0), enc_i(1, 0, 2, 0),
          enc_r(0, 2, 3, 1, 2), enc_sw(0, 3),
          enc_i(2, 0, 4, 0), enc_i(5, 0, 5, 0),
          enc_r(32, 0, 6, 4, 5), enc_sw(4, 6),
          enc_b(8, 4, 5), enc_sw(8, 4),
          enc_i(9, 0, 8, 0), 32'h12345437,
          enc_sw(12, 8), enc_b(0, 0, 0)};
    exp = '{{32'd0, 32'd1}, {32'd4, 32'hFFFFFFFD},
            {32'd8, 32'd2}, {32'd12, 32'd9}};
    start_prog(p);
    repeat (30) @(negedge clk);
    total++;
    if (st_q.size() !== exp.size()) begin
      bad++;
      $display("FAIL alu_nstores got %0d want %0d",
               st_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < st_q.size(); i++) begin
      total++;
      if (st_q[i] !== exp[i]) begin
        bad++;
        $display("FAIL alu_store%0d got %h want %h",
                 i, st_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_random_alu;
    logic [31:0] p[$];
    logic [63:0] exp[$];
    logic [31:0] r3, r4, va;
    int a, b, c, rop, iop;
    int rf7[5] = '{0, 32, 0, 0, 0};
    int rf3[5] = '{0, 0, 7, 6, 2};
    int if3[4] = '{0, 7, 6, 2};
    for (int it = 0; it < 8; it++) begin
      a = int'($urandom_range(0, 4095)) - 2048;
      b = ($urandom_range(0, 3) == 0) ? a
          : int'($urandom_range(0, 4095)) - 2048;
      c = int'($urandom_range(0, 4095)) - 2048;
      rop = $urandom_range(0, 4);
      iop = $urandom_range(0, 3);
      case (rop)
        0: r3 = a + b;
        1: r3 = a - b;
        2: r3 = a & b;
        3: r3 = a | b;
        default: r3 = (a < b) ? 1 : 0;
      endcase
      case (iop)
        0: r4 = a + c;
        1: r4 = a & c;
        2: r4 = a | c;
        default: r4 = (a < c) ? 1 : 0;
      endcase
      va = a;
      p = '{enc_i(a, 0, 1, 0), enc_i(b, 0, 2, 0),
            enc_r(rf7[rop], rf3[rop], 3, 1, 2),
            enc_i(c, if3[iop], 4, 1),
            enc_sw(0, 3), enc_sw(4, 4),
            enc_b(8, 1, 2), enc_sw(8, 1),
            enc_lw(4, 5), enc_sw(12, 5),
            enc_j(8, 6), enc_sw(16, 0),
            enc_sw(20, 6), enc_b(0, 0, 0)};
      exp.delete();
      exp.push_back({32'd0, r3});
      exp.push_back({32'd4, r4});
      if (a != b) exp.push_back({32'd8, va});
      exp.push_back({32'd12, r4});
      exp.push_back({32'd20, 32'd44});
      start_prog(p);
      repeat (30) @(negedge clk);
      total++;
      if (st_q.size() !== exp.size()) begin
        bad++;
        $display("FAIL rnd%0d_nstores got %0d want %0d",
                 it, st_q.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < st_q.size(); i++) begin
        total++;
        if (st_q[i] !== exp[i]) begin
          bad++;
          $display("FAIL rnd%0d_store%0d got %h want %h",
                   it, i, st_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_colour_vga;
    logic [31:0] p[$];
    logic [63:0] exp[$];
    int h, v, hs_low, first_low;
    logic [13:0] want;
    logic act;
    p = '{enc_i(123, 0, 2, 0), enc_sw(0, 2),
          enc_i(2047, 0, 1, 0), enc_i(1803, 0, 1, 1),
          enc_sw(256, 1), enc_lw(0, 3), enc_sw(4, 3),
          enc_lw(256, 4), enc_sw(8, 4),
          enc_sw(300, 2), enc_lw(300, 5), enc_sw(12, 5),
          enc_b(0, 0, 0)};
    exp = '{{32'd0, 32'd123}, {32'd256, 32'hF0A},
            {32'd4, 32'd123}, {32'd8, 32'd0},
            {32'd300, 32'd123}, {32'd12, 32'd0}};
    start_prog(p);
    hs_low = 0;
    first_low = -1;
    for (int n = 0; n < 3 * 3200; n++) begin
      @(negedge clk);
      h = (n / 4) % 800;
      v = (n / 3200) % 525;
      act = (h < 640) && (v < 480);
      want[13:2] = (act && n > 4) ? 12'hF0A : 12'h000;
      want[1] = !(h >= 656 && h <= 751);
      want[0] = !(v >= 490 && v <= 491);
      total++;
      if ({VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O} !== want) begin
        bad++;
        $display("FAIL vga_n%0d got %h want %h", n,
                 {VGA_R, VGA_G, VGA_B, VGA_HS_O, VGA_VS_O}, want);
      end
      if (n < 3200 && VGA_HS_O === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = n;
      end
    end
    total++;
    if (hs_low !== 384 || first_low !== 2624) begin
      bad++;
      $display("FAIL hsync_width got %0d@%0d want 384@2624",
               hs_low, first_low);
    end
    total++;
    if (st_q.size() !== exp.size()) begin
      bad++;
      $display("FAIL col_nstores got %0d want %0d",
               st_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < st_q.size(); i++) begin
      total++;
      if (st_q[i] !== exp[i]) begin
        bad++;
        $display("FAIL col_store%0d got %h want %h",
                 i, st_q[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_prog("boot");
    test_mid_reset();
    test_alu_directed();
    test_random_alu();
    test_colour_vga();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
